control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 88 ++++++++
 tb/tb_control_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: FETCH/EXEC/FAULT instruction sequencer with a 4-cycle substate budget.
// Optional retired-instruction counter enabled by RETIRE_COUNTER_EN.
module control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_instruction,
  input  logic        halt,
  input  logic [30:0] dec_controlWord,
  input  logic [1:0]  dec_nextState,
  input  logic [63:0] dec_K,
  input  logic        dec_valid,
  output logic [31:0] IR,
  output logic [1:0]  state,
  output logic [30:0] controlWord,
  output logic [63:0] K,
  output logic [1:0]  phase,
  output logic        fault
`ifdef RETIRE_COUNTER_EN
  ,
  output logic [31:0] retired
`endif
);
  typedef enum logic [1:0] {FETCH = 2'b00, EXEC = 2'b01, FAULT = 2'b10} phase_t;
  localparam logic [30:0] FETCH_WORD = 31'h20000000;
  phase_t ph, ph_n;
  logic [31:0] ir_n;
  logic [1:0] st_n, cnt, cnt_n;
  logic done;
  always_ff @(posedge clock) begin
    if (reset) begin
      ph <= FETCH;
      IR <= '0;
      state <= '0;
      cnt <= '0;
    end else begin
      ph <= ph_n;
      IR <= ir_n;
      state <= st_n;
      cnt <= cnt_n;
    end
  end
  // cnt holds the number of EXEC cycles already spent on the current instruction
  always_comb begin
    ph_n = ph;
    ir_n = IR;
    st_n = state;
    cnt_n = cnt;
    controlWord = '0;
    K = '0;
    done = 1'b0;
    if (!reset) begin
      case (ph)
        FETCH: if (!halt) begin
          controlWord = FETCH_WORD;
          ir_n = mem_instruction;
          st_n = '0;
          cnt_n = '0;
          ph_n = EXEC;
        end
        EXEC: if (dec_valid) begin
          controlWord = dec_controlWord;
          K = dec_K;
          if (dec_nextState == 2'b00) begin
            st_n = '0;
            ph_n = FETCH;
            done = 1'b1;
          end else if (cnt == 2'd3) ph_n = FAULT;
          else begin
            st_n = dec_nextState;
            cnt_n = cnt + 2'd1;
          end
        end else ph_n = FAULT;
        default: ph_n = ph;
      endcase
    end
  end
  assign phase = ph;
  assign fault = (ph == FAULT);
`ifdef RETIRE_COUNTER_EN
  always_ff @(posedge clock) begin
    if (reset) retired <= '0;
    else if (done) retired <= retired + 32'd1;
  end
`else
  logic unused_done;
  assign unused_done = done;
`endif
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scoreboard bench for control_sequencer.
module tb_control_sequencer;
  logic clock = 1'b0, reset = 1'b1, halt = 1'b0, dec_valid = 1'b0;
  logic [31:0] mem_instruction = '0, IR;
  logic [30:0] dec_controlWord, controlWord;
  logic [1:0] dec_nextState = '0, state, phase;
  logic [63:0] dec_K, K;
  logic fault;
  int checks = 0, passes = 0;
`ifdef RETIRE_COUNTER_EN
  logic [31:0] retired;
`endif
  typedef struct {
    string tag;
    logic [1:0] ph, st;
    logic [31:0] ir;
    logic [30:0] cw;
    logic [63:0] k;
  } exp_t;
  exp_t q[$];
  localparam logic [30:0] F = 31'h20000000;
  localparam logic [31:0] I0 = 32'hD61F0120, I1 = 32'h8B020020, I2 = 32'hF8400001, I3 = 32'h12345678;

  control_sequencer dut (
    .clock(clock), .reset(reset), .mem_instruction(mem_instruction), .halt(halt),
    .dec_controlWord(dec_controlWord), .dec_nextState(dec_nextState), .dec_K(dec_K),
    .dec_valid(dec_valid), .IR(IR), .state(state), .controlWord(controlWord), .K(K),
    .phase(phase), .fault(fault)
`ifdef RETIRE_COUNTER_EN
    , .retired(retired)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [30:0] cw_of(input logic [1:0] s);
    return {s, 29'h0ABCDE1};
  endfunction
  function automatic logic [63:0] k_of(input logic [31:0] i, input logic [1:0] s);
    return {i, 30'h0, s};
  endfunction

  // decoder stand-in: its outputs depend on (IR, state) like the real opcode decoder
  assign dec_controlWord = cw_of(state);
  assign dec_K = k_of(IR, state);

  task automatic cyc(input string tag, input logic r, h, v, input logic [1:0] ns,
                     input logic [31:0] mem, input logic [1:0] eph, est,
                     input logic [31:0] eir, input logic [30:0] ecw, input logic [63:0] ek);
    exp_t e;
    @(negedge clock);
    reset = r;
    halt = h;
    dec_valid = v;
    dec_nextState = ns;
    mem_instruction = mem;
    q.push_back('{tag, eph, est, eir, ecw, ek});
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert ({phase, state, IR, controlWord, K, fault} === {e.ph, e.st, e.ir, e.cw, e.k, e.ph == 2'b10})
        passes++;
      else $error("FAIL %s: got phase=%h state=%h IR=%h cw=%h K=%h fault=%b, expected phase=%h state=%h IR=%h cw=%h K=%h fault=%b",
                  e.tag, phase, state, IR, controlWord, K, fault, e.ph, e.st, e.ir, e.cw, e.k, e.ph == 2'b10);
    end
  endtask

`ifdef RETIRE_COUNTER_EN
  task automatic chk_ret(input string tag, input logic [31:0] exp_r);
    checks++;
    assert (retired === exp_r) passes++;
    else $error("FAIL %s: got retired=%h, expected %h", tag, retired, exp_r);
  endtask
`endif

  initial begin
    cyc("reset_nop",   1, 0, 1, 2'b00, I0, 2'b00, 2'b00, 32'h0, 31'h0, 64'h0);
    cyc("fetch1",      0, 0, 1, 2'b00, I0, 2'b00, 2'b00, 32'h0, F, 64'h0);
    cyc("exec1",       0, 0, 1, 2'b00, I0, 2'b01, 2'b00, I0, cw_of(2'b00), k_of(I0, 2'b00));
    cyc("back_fetch",  0, 0, 1, 2'b00, I1, 2'b00, 2'b00, I0, F, 64'h0);
`ifdef RETIRE_COUNTER_EN
    chk_ret("retired_1", 32'd1);
`endif
    cyc("multi_s0",    0, 1, 1, 2'b01, I1, 2'b01, 2'b00, I1, cw_of(2'b00), k_of(I1, 2'b00));
    cyc("multi_s1",    0, 1, 1, 2'b10, I1, 2'b01, 2'b01, I1, cw_of(2'b01), k_of(I1, 2'b01));
    cyc("multi_s2",    0, 0, 1, 2'b00, I1, 2'b01, 2'b10, I1, cw_of(2'b10), k_of(I1, 2'b10));
    for (int i = 0; i < 5; i++)
      cyc("halt_fetch", 0, 1, 1, 2'b00, I2, 2'b00, 2'b00, I1, 31'h0, 64'h0);
`ifdef RETIRE_COUNTER_EN
    chk_ret("retired_2", 32'd2);
`endif
    cyc("fetch_i2",    0, 0, 1, 2'b01, I2, 2'b00, 2'b00, I1, F, 64'h0);
    cyc("budget_1",    0, 0, 1, 2'b01, I2, 2'b01, 2'b00, I2, cw_of(2'b00), k_of(I2, 2'b00));
    cyc("budget_2",    0, 0, 1, 2'b01, I2, 2'b01, 2'b01, I2, cw_of(2'b01), k_of(I2, 2'b01));
    cyc("budget_3",    0, 0, 1, 2'b01, I2, 2'b01, 2'b01, I2, cw_of(2'b01), k_of(I2, 2'b01));
    cyc("budget_4",    0, 0, 1, 2'b01, I2, 2'b01, 2'b01, I2, cw_of(2'b01), k_of(I2, 2'b01));
    cyc("budget_fault",0, 0, 1, 2'b01, I2, 2'b10, 2'b01, I2, 31'h0, 64'h0);
    cyc("reset_fault", 1, 0, 1, 2'b01, I2, 2'b10, 2'b01, I2, 31'h0, 64'h0);
    cyc("post_reset",  0, 0, 0, 2'b00, I3, 2'b00, 2'b00, 32'h0, F, 64'h0);
`ifdef RETIRE_COUNTER_EN
    chk_ret("retired_clr", 32'd0);
`endif
    cyc("invalid",     0, 0, 0, 2'b00, I0, 2'b01, 2'b00, I3, 31'h0, 64'h0);
    for (int i = 0; i < 10; i++)
      cyc("sticky_fault", 0, i[0], 1, 2'b00, I0, 2'b10, 2'b00, I3, 31'h0, 64'h0);
    cyc("reset_fault2",1, 0, 1, 2'b00, I0, 2'b10, 2'b00, I3, 31'h0, 64'h0);
    cyc("refetch",     0, 0, 1, 2'b10, I0, 2'b00, 2'b00, 32'h0, F, 64'h0);
    cyc("mid_s0",      0, 0, 1, 2'b10, I0, 2'b01, 2'b00, I0, cw_of(2'b00), k_of(I0, 2'b00));
    cyc("mid_reset",   1, 0, 1, 2'b01, I0, 2'b01, 2'b10, I0, 31'h0, 64'h0);
    cyc("after_reset", 0, 1, 1, 2'b00, I0, 2'b00, 2'b00, 32'h0, 31'h0, 64'h0);
`ifdef RETIRE_COUNTER_EN
    chk_ret("retired_mid", 32'd0);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
